// File: rtl/param_user_auth.sv
// Multi-user login controller: collects an ID then a password as 4-bit digits and checks them
// against parameter credential tables, with guest login, failed-attempt lockout and entry timeout.
module param_user_auth #(
    parameter int NUM_USERS      = 4,
    parameter int ID_DIGITS      = 4,
    parameter int PW_DIGITS      = 4,
    parameter int ID_W           = 5,
    parameter logic [NUM_USERS*4*ID_DIGITS-1:0] ID_TABLE = {16'h4444, 16'h3333, 16'h2222, 16'h1234},
    parameter logic [NUM_USERS*4*PW_DIGITS-1:0] PW_TABLE = {16'h0004, 16'h0003, 16'h0002, 16'h5678},
    parameter int MAX_FAILS      = 3,
    parameter int LOCK_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Game_Enter,
    input  logic [3:0]      User_digit,
    input  logic            GCLogOut,
    output logic            LogIn,
    output logic            LogOut,
    output logic [ID_W-1:0] InternalID,
    output logic            Locked,
    output logic            AuthFail
);

    localparam int IDW    = 4 * ID_DIGITS;
    localparam int PWW    = 4 * PW_DIGITS;
    localparam int MAXD   = (ID_DIGITS > PW_DIGITS) ? ID_DIGITS : PW_DIGITS;
    localparam int CNT_W  = $clog2(MAXD + 1);
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LCK_W  = $clog2(LOCK_CYCLES + 1);
    localparam int FL_W   = $clog2(MAX_FAILS + 1);

    localparam logic [CNT_W-1:0] ID_LAST   = CNT_W'(ID_DIGITS - 1);
    localparam logic [CNT_W-1:0] PW_LAST   = CNT_W'(PW_DIGITS - 1);
    localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LCK_W-1:0] LOCK_LAST = LCK_W'(LOCK_CYCLES - 1);
    localparam logic [FL_W-1:0]  FAIL_MAX  = FL_W'(MAX_FAILS);

    typedef enum logic [1:0] {
        ID_ENTRY,
        PW_ENTRY,
        LOGGED_IN,
        LOCKED
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDW-1:0]   r_id_shift;
    logic [PWW-1:0]   r_pw_shift;
    logic             r_id_valid;
    logic [ID_W-1:0]  r_user_idx;
    logic [TMR_W-1:0] r_timer;
    logic [LCK_W-1:0] r_lock_cnt;
    logic [FL_W-1:0]  r_fail;

    logic [IDW-1:0]   w_id_next;
    logic [PWW-1:0]   w_pw_next;
    logic             w_match;
    logic [ID_W-1:0]  w_idx;
    logic [PWW-1:0]   w_exp_pw;
    logic             w_pw_ok;
    logic [FL_W-1:0]  w_fail_inc;

    assign w_id_next = IDW'({r_id_shift, User_digit});
    assign w_pw_next = PWW'({r_pw_shift, User_digit});

    // Descending scan so the lowest matching table index is the one left standing.
    always_comb begin
        w_match = 1'b0;
        w_idx   = '0;
        for (int i = NUM_USERS - 1; i >= 0; i--) begin
            if (ID_TABLE[i*IDW +: IDW] == w_id_next) begin
                w_match = 1'b1;
                w_idx   = ID_W'(i);
            end
        end
    end

    always_comb begin
        w_exp_pw = '0;
        for (int i = 0; i < NUM_USERS; i++) begin
            if (r_user_idx == ID_W'(i)) begin
                w_exp_pw = PW_TABLE[i*PWW +: PWW];
            end
        end
    end

    assign w_pw_ok    = r_id_valid && (w_pw_next == w_exp_pw);
    assign w_fail_inc = (r_fail == FAIL_MAX) ? r_fail : r_fail + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ID_ENTRY;
            r_cnt      <= '0;
            r_id_shift <= '0;
            r_pw_shift <= '0;
            r_id_valid <= 1'b0;
            r_user_idx <= '0;
            r_timer    <= '0;
            r_lock_cnt <= '0;
            r_fail     <= '0;
            LogIn      <= 1'b0;
            LogOut     <= 1'b1;
            InternalID <= '0;
            Locked     <= 1'b0;
            AuthFail   <= 1'b0;
        end else begin
            AuthFail <= 1'b0;
            case (r_state)
                ID_ENTRY: begin
                    if (Game_Enter) begin
                        if (r_cnt == ID_LAST) begin
                            r_cnt      <= '0;
                            r_id_shift <= '0;
                            if (w_id_next == '0) begin
                                r_state    <= LOGGED_IN;
                                LogIn      <= 1'b1;
                                LogOut     <= 1'b0;
                                InternalID <= '0;
                                r_fail     <= '0;
                            end else begin
                                r_state    <= PW_ENTRY;
                                r_id_valid <= w_match;
                                r_user_idx <= w_idx;
                                r_pw_shift <= '0;
                                r_timer    <= '0;
                            end
                        end else begin
                            r_cnt      <= r_cnt + 1'b1;
                            r_id_shift <= w_id_next;
                        end
                    end
                end

                PW_ENTRY: begin
                    if (Game_Enter) begin
                        r_timer <= '0;
                        if (r_cnt == PW_LAST) begin
                            r_cnt      <= '0;
                            r_pw_shift <= '0;
                            if (w_pw_ok) begin
                                r_state    <= LOGGED_IN;
                                LogIn      <= 1'b1;
                                LogOut     <= 1'b0;
                                InternalID <= ID_W'(r_user_idx + 1'b1);
                                r_fail     <= '0;
                            end else begin
                                AuthFail <= 1'b1;
                                r_fail   <= w_fail_inc;
                                if (w_fail_inc == FAIL_MAX) begin
                                    r_state    <= LOCKED;
                                    Locked     <= 1'b1;
                                    r_lock_cnt <= '0;
                                end else begin
                                    r_state <= ID_ENTRY;
                                end
                            end
                        end else begin
                            r_cnt      <= r_cnt + 1'b1;
                            r_pw_shift <= w_pw_next;
                        end
                    end else if (r_timer == TMO_LAST) begin
                        // Abandoned entry: drop partial digits without counting a failure.
                        r_state    <= ID_ENTRY;
                        r_cnt      <= '0;
                        r_pw_shift <= '0;
                        r_timer    <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                LOGGED_IN: begin
                    if (GCLogOut) begin
                        r_state    <= ID_ENTRY;
                        r_cnt      <= '0;
                        LogIn      <= 1'b0;
                        LogOut     <= 1'b1;
                        InternalID <= '0;
                    end
                end

                LOCKED: begin
                    if (r_lock_cnt == LOCK_LAST) begin
                        r_state    <= ID_ENTRY;
                        r_cnt      <= '0;
                        r_lock_cnt <= '0;
                        r_fail     <= '0;
                        Locked     <= 1'b0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= ID_ENTRY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_user_auth.sv
// Directed self-checking bench for param_user_auth using the default credential tables.
module tb_param_user_auth;

    logic       clk;
    logic       rst;
    logic       Game_Enter;
    logic [3:0] User_digit;
    logic       GCLogOut;
    logic       LogIn;
    logic       LogOut;
    logic [4:0] InternalID;
    logic       Locked;
    logic       AuthFail;

    int testsRun;
    int testsFailed;
    int authFailCount;
    int lockedCycles;
    int logInCycles;

    param_user_auth dut (
        .clk        (clk),
        .rst        (rst),
        .Game_Enter (Game_Enter),
        .User_digit (User_digit),
        .GCLogOut   (GCLogOut),
        .LogIn      (LogIn),
        .LogOut     (LogOut),
        .InternalID (InternalID),
        .Locked     (Locked),
        .AuthFail   (AuthFail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        authFailCount = 0;
        lockedCycles  = 0;
        logInCycles   = 0;
    end

    always @(negedge clk) begin
        if (AuthFail === 1'b1) authFailCount++;
        if (Locked === 1'b1)   lockedCycles++;
        if (LogIn === 1'b1)    logInCycles++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // One digit strobe; returns 1ns after the edge that sampled it.
    task automatic applyStimulus(input logic [3:0] d);
        @(posedge clk) #1;
        Game_Enter = 1'b1;
        User_digit = d;
        @(posedge clk) #1;
        Game_Enter = 1'b0;
    endtask

    task automatic enterCode(input logic [15:0] code);
        logic [15:0] c;
        c = code;
        for (int k = 3; k >= 0; k--) applyStimulus(c[k*4 +: 4]);
    endtask

    task automatic logoutPulse();
        @(posedge clk) #1;
        GCLogOut = 1'b1;
        @(posedge clk) #1;
        GCLogOut = 1'b0;
    endtask

    initial begin
        int snapFail;
        int snapLock;
        int snapLogIn;
        int n;

        testsRun    = 0;
        testsFailed = 0;
        Game_Enter  = 1'b0;
        User_digit  = 4'h0;
        GCLogOut    = 1'b0;
        rst         = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_login",  32'(LogIn),      32'd0);
        checkOutput("rst_logout", 32'(LogOut),     32'd1);
        checkOutput("rst_id",     32'(InternalID), 32'd0);
        checkOutput("rst_locked", 32'(Locked),     32'd0);
        checkOutput("rst_fail",   32'(AuthFail),   32'd0);
        @(negedge clk) rst = 1'b1;

        // User 1234 / 5678
        enterCode(16'h1234);
        applyStimulus(4'h5);
        applyStimulus(4'h6);
        applyStimulus(4'h7);
        checkOutput("t1_pre_login", 32'(LogIn), 32'd0);
        applyStimulus(4'h8);
        checkOutput("t1_login",  32'(LogIn),      32'd1);
        checkOutput("t1_logout", 32'(LogOut),     32'd0);
        checkOutput("t1_id",     32'(InternalID), 32'd1);
        logoutPulse();
        checkOutput("t1_out_login", 32'(LogIn),      32'd0);
        checkOutput("t1_out_led",   32'(LogOut),     32'd1);
        checkOutput("t1_out_id",    32'(InternalID), 32'd0);

        // Guest, strobes ignored while logged in, then logout with a simultaneous strobe
        enterCode(16'h0000);
        checkOutput("t2_guest_login", 32'(LogIn),      32'd1);
        checkOutput("t2_guest_id",    32'(InternalID), 32'd0);
        enterCode(16'h1234);
        checkOutput("t2_ignored", 32'(LogIn), 32'd1);
        @(posedge clk) #1;
        GCLogOut   = 1'b1;
        Game_Enter = 1'b1;
        User_digit = 4'h9;
        @(posedge clk) #1;
        GCLogOut   = 1'b0;
        Game_Enter = 1'b0;
        checkOutput("t2_simul_logout", 32'(LogIn), 32'd0);
        enterCode(16'h1234);
        enterCode(16'h5678);
        checkOutput("t2_digit_dropped", 32'(InternalID), 32'd1);
        logoutPulse();

        // Unknown ID 9999 is only reported at the end of the password
        snapFail  = authFailCount;
        snapLogIn = logInCycles;
        enterCode(16'h9999);
        checkOutput("t3_no_early_fail", 32'(authFailCount - snapFail), 32'd0);
        enterCode(16'h1111);
        checkOutput("t3_fail_pulse", 32'(AuthFail), 32'd1);
        @(posedge clk) #1;
        checkOutput("t3_fail_cleared", 32'(AuthFail), 32'd0);
        checkOutput("t3_fail_count",   32'(authFailCount - snapFail), 32'd1);
        checkOutput("t3_no_login",     32'(logInCycles - snapLogIn),  32'd0);
        enterCode(16'h1234);
        enterCode(16'h5678);
        checkOutput("t3_recover", 32'(LogIn), 32'd1);
        logoutPulse();

        // Three wrong passwords on 2222 lock the controller
        enterCode(16'h2222);
        enterCode(16'h1111);
        checkOutput("t4_lock_after1", 32'(Locked), 32'd0);
        enterCode(16'h2222);
        enterCode(16'h1111);
        checkOutput("t4_lock_after2", 32'(Locked), 32'd0);
        snapLock = lockedCycles;
        enterCode(16'h2222);
        enterCode(16'h1111);
        checkOutput("t4_locked", 32'(Locked),   32'd1);
        checkOutput("t4_fail3",  32'(AuthFail), 32'd1);
        enterCode(16'h2222);
        enterCode(16'h0002);
        checkOutput("t4_ignored", 32'(LogIn), 32'd0);
        n = 0;
        while (Locked === 1'b1 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("t4_unlock",      32'(Locked), 32'd0);
        checkOutput("t4_lock_length", 32'(lockedCycles - snapLock), 32'd1000);
        enterCode(16'h2222);
        enterCode(16'h0002);
        checkOutput("t4_login", 32'(LogIn),      32'd1);
        checkOutput("t4_id",    32'(InternalID), 32'd2);
        logoutPulse();

        // Strobe landing exactly on the timeout cycle is accepted
        enterCode(16'h1234);
        applyStimulus(4'h5);
        repeat (4998) @(posedge clk);
        applyStimulus(4'h6);
        applyStimulus(4'h7);
        applyStimulus(4'h8);
        checkOutput("t5_edge_login", 32'(LogIn), 32'd1);
        logoutPulse();

        // Password-entry timeout drops digits without a failure
        snapFail = authFailCount;
        enterCode(16'h1234);
        applyStimulus(4'h5);
        applyStimulus(4'h6);
        repeat (5000) @(posedge clk);
        enterCode(16'h1234);
        enterCode(16'h5678);
        checkOutput("t5_retry_login", 32'(LogIn),      32'd1);
        checkOutput("t5_retry_id",    32'(InternalID), 32'd1);
        checkOutput("t5_no_fail",     32'(authFailCount - snapFail), 32'd0);
        logoutPulse();

        // Reset after 6 of 8 digits discards them
        enterCode(16'h3333);
        applyStimulus(4'h0);
        applyStimulus(4'h0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t6_rst_login",  32'(LogIn),  32'd0);
        checkOutput("t6_rst_logout", 32'(LogOut), 32'd1);
        @(negedge clk) rst = 1'b1;
        enterCode(16'h3333);
        enterCode(16'h0003);
        checkOutput("t6_login", 32'(LogIn),      32'd1);
        checkOutput("t6_id",    32'(InternalID), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t6_async_login", 32'(LogIn),      32'd0);
        checkOutput("t6_async_id",    32'(InternalID), 32'd0);
        checkOutput("t6_async_led",   32'(LogOut),     32'd1);
        @(negedge clk) rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
